// File: rtl/mem_noc_sram_resp_pkg.sv
// Channel payload types, defaults and FSM encoding shared by the NoC SRAM responder and its bench.
package mem_noc_sram_resp_pkg;

  localparam int MEMNOC_SRAM_AW = 10;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cache_mem_if_aw_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cache_mem_if_ar_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
  } cache_mem_if_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } cache_mem_if_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } cache_mem_if_r_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_DRAIN
  } memnoc_state_e;

endpackage

// File: rtl/mem_noc_rsp_fifo.sv
// Small synchronous FIFO with occupancy count; the caller guarantees no push when full
// and no pop when empty.
module mem_noc_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_noc_sram_resp.sv
// NoC slave-port responder backing AW/W/AR bursts with a 1-cycle-latency single-port SRAM.
//   state       | meaning
//   ST_IDLE     | arbitrate AW vs AR; beat 0 of a read issues in the AR handshake cycle
//   ST_WR_DATA  | write one SRAM word per W beat until wlast
//   ST_WR_RESP  | hold B until bready
//   ST_RD_ISSUE | issue remaining read beats while the R buffer has credit
//   ST_RD_DRAIN | wait for the final beat to leave the R buffer
module mem_noc_sram_resp
  import mem_noc_sram_resp_pkg::*;
#(
  parameter int SRAM_AW        = MEMNOC_SRAM_AW,
  parameter int RSP_FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_awvalid,
  input  logic [$bits(cache_mem_if_aw_t)-1:0]  req_aw,
  output logic                                 req_awready,
  input  logic                                 req_wvalid,
  input  logic [$bits(cache_mem_if_w_t)-1:0]   req_w,
  output logic                                 req_wready,
  input  logic                                 req_arvalid,
  input  logic [$bits(cache_mem_if_ar_t)-1:0]  req_ar,
  output logic                                 req_arready,
  output logic                                 rsp_bvalid,
  output logic [$bits(cache_mem_if_b_t)-1:0]   rsp_b,
  input  logic                                 rsp_bready,
  output logic                                 rsp_rvalid,
  output logic [$bits(cache_mem_if_r_t)-1:0]   rsp_r,
  input  logic                                 rsp_rready,
  output logic                                 sram_en,
  output logic                                 sram_we,
  output logic [SRAM_AW-1:0]                   sram_addr,
  output logic [DATA_W-1:0]                    sram_wdata,
  input  logic [DATA_W-1:0]                    sram_rdata,
  output logic                                 clk_en
);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH+1);
  localparam int OCC_W = CNT_W + 1;

  cache_mem_if_aw_t aw;
  cache_mem_if_ar_t ar;
  cache_mem_if_w_t  w;
  cache_mem_if_r_t  fifo_din;

  memnoc_state_e    state_q, state_d;
  logic             rr_q, rr_d;
  logic [LEN_W-1:0] beat_q, beat_d, len_q, len_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             inflight_q, inflight_d, inflight_last_q, inflight_last_d;

  logic             fifo_empty, rsp_pop, rd_credit, grant_rd;
  logic [CNT_W-1:0] fifo_cnt;
  logic             unused_bits;

  assign aw = req_aw;
  assign ar = req_ar;
  assign w  = req_w;
  assign unused_bits = ^{aw.addr[ADDR_W-1:SRAM_AW], ar.addr[ADDR_W-1:SRAM_AW], w.id};

  assign grant_rd   = req_arvalid & (~req_awvalid | rr_q);
  assign rsp_rvalid = ~fifo_empty;
  assign rsp_pop    = rsp_rvalid & rsp_rready;
  assign rsp_b      = {id_q, 2'b00};
  assign sram_wdata = w.data;
  assign fifo_din   = '{id: id_q, data: sram_rdata, resp: 2'b00, last: inflight_last_q};
  assign clk_en     = (state_q != ST_IDLE) | ~fifo_empty | req_awvalid | req_arvalid;

  // A read may issue only if its data is guaranteed a slot when it lands next cycle.
  assign rd_credit = (OCC_W'(fifo_cnt) + OCC_W'(inflight_q))
                   < (OCC_W'(RSP_FIFO_DEPTH) + OCC_W'(rsp_pop));

  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    beat_d          = beat_q;
    len_d           = len_q;
    base_d          = base_q;
    id_d            = id_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    req_awready     = 1'b0;
    req_arready     = 1'b0;
    req_wready      = 1'b0;
    rsp_bvalid      = 1'b0;
    sram_en         = 1'b0;
    sram_we         = 1'b0;
    sram_addr       = base_q + SRAM_AW'(beat_q);
    case (state_q)
      ST_IDLE: begin
        req_awready = req_awvalid & ~grant_rd;
        req_arready = grant_rd;
        if (req_awvalid && req_arvalid) rr_d = ~rr_q;
        if (req_awready) begin
          id_d    = aw.id;
          base_d  = aw.addr[SRAM_AW-1:0];
          len_d   = aw.len;
          beat_d  = '0;
          state_d = ST_WR_DATA;
        end else if (req_arready) begin
          id_d            = ar.id;
          base_d          = ar.addr[SRAM_AW-1:0];
          len_d           = ar.len;
          beat_d          = LEN_W'(1);
          sram_en         = 1'b1;
          sram_addr       = ar.addr[SRAM_AW-1:0];
          inflight_d      = 1'b1;
          inflight_last_d = (ar.len == '0);
          state_d         = (ar.len == '0) ? ST_RD_DRAIN : ST_RD_ISSUE;
        end
      end
      ST_WR_DATA: begin
        req_wready = 1'b1;
        if (req_wvalid) begin
          sram_en = 1'b1;
          sram_we = 1'b1;
          beat_d  = beat_q + LEN_W'(1);
          if (w.last) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        rsp_bvalid = 1'b1;
        if (rsp_bready) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        if (rd_credit) begin
          sram_en         = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (beat_q == len_q);
          beat_d          = beat_q + LEN_W'(1);
          if (beat_q == len_q) state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (!inflight_q && (fifo_cnt == '0 || (fifo_cnt == CNT_W'(1) && rsp_pop)))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rr_q            <= 1'b0;
      beat_q          <= '0;
      len_q           <= '0;
      base_q          <= '0;
      id_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_q            <= rr_d;
      beat_q          <= beat_d;
      len_q           <= len_d;
      base_q          <= base_d;
      id_q            <= id_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  mem_noc_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH ($bits(cache_mem_if_r_t))
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (rsp_pop),
    .dout  (rsp_r),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: doc/mem_noc_sram_resp.md
Name: mem_noc_sram_resp

Overview:
- Memory-side responder for the cache_mem_if AXI-style channels: accepts AW/W/AR requests arriving from the NoC and returns B/R responses carrying the original ID.
- Backs the requests with a single-port synchronous SRAM macro that has 1-cycle read latency.
- Sits on one NoC slave port (mem_req_if_*/mem_resp_if_*) in place of an external memory controller, for small on-chip memories and simulation.

Parameters:
- SRAM_AW, 10, SRAM word-address width; depth = 2**SRAM_AW words.
- RSP_FIFO_DEPTH, 2, R-channel output buffer depth; must be >= 2 to absorb SRAM read latency under backpressure.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_awvalid  in  1 / req_aw  in  $bits(cache_mem_if_aw_t) / req_awready  out  1  write-address channel.
- req_wvalid  in  1 / req_w  in  $bits(cache_mem_if_w_t) / req_wready  out  1  write-data channel.
- req_arvalid  in  1 / req_ar  in  $bits(cache_mem_if_ar_t) / req_arready  out  1  read-address channel.
- rsp_bvalid  out  1 / rsp_b  out  $bits(cache_mem_if_b_t) / rsp_bready  in  1  write-response channel.
- rsp_rvalid  out  1 / rsp_r  out  $bits(cache_mem_if_r_t) / rsp_rready  in  1  read-data channel.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  $bits(wdata)  SRAM write data.
- sram_rdata  in  $bits(rdata)  SRAM read data, valid the cycle after en & !we.
- clk_en  out  1  high whenever the block is not idle; feeds the upstream clock gate.

Behaviour:
- Reset: FSM=IDLE; all ready/valid outputs 0; sram_en/sram_we 0; beat counter 0; rsp FIFO empty; arbitration pointer = write-first.
- Burst length: beats = len+1. Word address = addr[SRAM_AW-1:0] + beat, wrapping modulo 2**SRAM_AW.
- FSM states:
  - IDLE:
    - awready = !arb_rd_pending; arready = the complement rule below.
    - If exactly one of awvalid/arvalid is high, grant it.
    - If both are high, grant per round-robin pointer, then toggle the pointer.
    - Handshake latches id/addr/len; AW handshake -> WR_DATA, AR handshake -> RD_ISSUE.
    - awready and arready are never both 1 in the same cycle.
  - WR_DATA:
    - wready = 1.
    - Each w handshake drives sram_en=1, sram_we=1 at base+beat, then beat++.
    - Burst ends on the beat with wlast=1, independent of len; state -> WR_RESP.
    - wid is not checked.
  - WR_RESP:
    - bvalid=1, b.bid=latched awid.
    - Holds stable until bready, then -> IDLE.
    - Minimum AW-to-B latency = beats+1 cycles.
  - RD_ISSUE:
    - Issues a read (sram_en=1, sram_we=0) when FIFO free slots minus in-flight reads > 0.
    - beat++ per issue.
    - After issuing beat len -> RD_DRAIN.
  - RD_DRAIN:
    - Waits until the last beat has popped from the FIFO, then -> IDLE.
- R path:
  - Read data is captured into the FIFO the cycle after issue, tagged rid=latched arid and rlast=(beat==len).
  - rvalid = FIFO non-empty; pop on rvalid & rready.
  - Issue stalls when the FIFO is full, so no data is ever dropped under arbitrary rready.
  - Minimum AR-to-first-R latency = 2 cycles; full-rate streaming at 1 beat/cycle when rready=1.
- Single outstanding transaction: no AW/AR is accepted outside IDLE.
- Reset asserted mid-burst: immediate return to IDLE. Partial writes remain in SRAM; no B/R is issued.
- clk_en = (state != IDLE) | FIFO non-empty | awvalid | arvalid.

Decomposition:
- Shared package (pygmy_intf_typedef): cache_mem_if_aw_t/w_t/ar_t/b_t/r_t are already there.
- Shared package (pygmy_cfg): add the MEMNOC_SRAM_AW default.
- Local: FSM state enum.
- Sub-module: mem_noc_rsp_fifo, a parameterised sync FIFO with count output, used for the R buffer.

Test Plan:
- Write burst: AW{addr=0x10,len=3,id=5}, 4 W beats 0xA0..0xA3, last with wlast -> SRAM words 0x10..0x13 hold 0xA0..0xA3; single B with bid=5.
- Read burst after the above: AR{addr=0x10,len=3,id=2}, rready=1 -> 4 R beats 0xA0..0xA3, rid=2, rlast only on beat 3; first rvalid 2 cycles after the AR handshake.
- Backpressure: same read with rready toggled 1-of-3 cycles -> identical data order, no drop or duplicate, FIFO never overflows.
- Simultaneous AW and AR valid from reset -> write granted first; next simultaneous pair -> read granted first.
- Wrap: AW{addr=0x3FE,len=3}, SRAM_AW=10 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-read after 2 R beats -> rvalid=0 next cycle; state IDLE; new AR accepted and returns correct data.
